// File: rtl/i2s_stream_ctrl_if.sv
// Upstream 16-bit valid/ready word stream from the FX2LP endpoint side.
// The controller takes the slave modport; the upstream source uses master.
interface i2s_stream_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/i2s_stream_ctrl.sv
// Playback sequencer for i2s_master: FIFO prefill, start/stop on frame boundaries, underrun fill.
// Optional macro I2S_STREAM_CTRL_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module i2s_stream_ctrl #(
    parameter int DEPTH        = 8,
    parameter int PREFILL      = 4,
    parameter int IDLE_TIMEOUT = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              word_size_in,
    i2s_stream_ctrl_if.slave  up,
    input  logic              data_req,
    output logic [15:0]       data_out,
    output logic              start_n,
    output logic              stop_n,
    output logic              word_size,
    output logic              running,
    output logic              underrun
`ifdef I2S_STREAM_CTRL_UNDERRUN_CNT_EN
    ,
    output logic [7:0]        underrun_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [CW-1:0] DEPTH_C      = CW'(DEPTH);
    localparam logic [CW-1:0] PREFILL_C    = CW'(PREFILL);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(IDLE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFILL,
        S_START,
        S_RUN,
        S_STOP
    } state_t;

    state_t        state;
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          dr_q;
    logic          cons;
    logic          serving;
    logic          empty;
    logic          wr_en;
    logic          pop;
    logic          under_ev;
    logic          upd_q;
    logic [1:0]    widx;
    logic [1:0]    widx_next;
    logic [1:0]    widx_last;
    logic          last_next;
    logic [TW-1:0] timer;

    assign cons        = data_req & ~dr_q;
    assign empty       = (count == '0);
    assign up.in_ready = (count != DEPTH_C);
    assign wr_en       = up.in_valid & up.in_ready;
    assign serving     = (state == S_START) | (state == S_RUN) | (state == S_STOP);
    assign pop         = cons & serving & ~empty;
    assign under_ev    = cons & empty & ((state == S_RUN) | (state == S_STOP));

    assign widx_last = word_size ? 2'd3 : 2'd1;
    assign last_next = (widx_next == widx_last);

    always_comb begin
        widx_next = widx + 2'd1;
        if (widx == widx_last) begin
            widx_next = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= up.in_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dr_q   <= 1'b0;
        end else begin
            dr_q <= data_req;
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // data_out is refreshed one clock after a served cons, so it settles
    // while data_req is still high and stays put through the low half.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            data_out  <= '0;
            start_n   <= 1'b1;
            stop_n    <= 1'b1;
            word_size <= 1'b0;
            running   <= 1'b0;
            underrun  <= 1'b0;
            widx      <= '0;
            timer     <= '0;
            upd_q     <= 1'b0;
        end else begin
            upd_q <= 1'b0;
            if (upd_q) begin
                data_out <= empty ? 16'h0000 : mem[rd_ptr];
            end
            if (under_ev) begin
                underrun <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        state     <= S_PREFILL;
                        word_size <= word_size_in;
                        underrun  <= 1'b0;
                        widx      <= '0;
                    end
                end
                S_PREFILL: begin
                    if (!enable) begin
                        state <= S_IDLE;
                    end else if (count >= PREFILL_C) begin
                        state    <= S_START;
                        data_out <= mem[rd_ptr];
                        start_n  <= 1'b0;
                        running  <= 1'b1;
                    end
                end
                S_START: begin
                    if (cons) begin
                        state   <= S_RUN;
                        start_n <= 1'b1;
                        upd_q   <= 1'b1;
                    end
                end
                S_RUN: begin
                    timer <= '0;
                    if (cons) begin
                        upd_q <= 1'b1;
                        widx  <= widx_next;
                    end
                    if (!enable) begin
                        state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (cons) begin
                        upd_q  <= 1'b1;
                        widx   <= widx_next;
                        stop_n <= ~last_next;
                        timer  <= '0;
                    end else if (timer == TIMEOUT_LAST) begin
                        state   <= S_IDLE;
                        stop_n  <= 1'b1;
                        running <= 1'b0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef I2S_STREAM_CTRL_UNDERRUN_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_cnt <= '0;
        end else if (state == S_IDLE && enable) begin
            underrun_cnt <= '0;
        end else if (under_ev && underrun_cnt != 8'hFF) begin
            underrun_cnt <= underrun_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_i2s_stream_ctrl.sv
// Directed bench for i2s_stream_ctrl; the bench plays the i2s_master side with 16-clock word slots.
module tb_i2s_stream_ctrl;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        word_size_in;
    logic        data_req;
    logic [15:0] data_out;
    logic        start_n;
    logic        stop_n;
    logic        word_size;
    logic        running;
    logic        underrun;
`ifdef I2S_STREAM_CTRL_UNDERRUN_CNT_EN
    logic [7:0]  underrun_cnt;
`endif

    int checks;
    int errors;

    i2s_stream_ctrl_if up_if ();

    i2s_stream_ctrl #(
        .DEPTH        (8),
        .PREFILL      (4),
        .IDLE_TIMEOUT (20)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .word_size_in (word_size_in),
        .up           (up_if),
        .data_req     (data_req),
        .data_out     (data_out),
        .start_n      (start_n),
        .stop_n       (stop_n),
        .word_size    (word_size),
        .running      (running),
        .underrun     (underrun)
`ifdef I2S_STREAM_CTRL_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic resetDut();
        enable         = 1'b0;
        data_req       = 1'b0;
        up_if.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic writeWord(input logic [15:0] d);
        up_if.in_valid = 1'b1;
        up_if.in_data  = d;
        @(negedge clk);
        up_if.in_valid = 1'b0;
    endtask

    task automatic waitStart();
        int n;
        n = 0;
        while (start_n !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("start_n_low_before_cons", start_n, 1'b0);
    endtask

    // One word slot: low half (word latched at its end), then data_req rises.
    task automatic applyStimulus(input bit wr, input logic [15:0] wdata,
                                 output logic [15:0] word, output logic sn);
        data_req = 1'b0;
        if (wr) begin
            up_if.in_valid = 1'b1;
            up_if.in_data  = wdata;
        end
        @(negedge clk);
        if (wr) begin
            up_if.in_valid = 1'b0;
        end
        repeat (6) @(negedge clk);
        word = data_out;
        @(negedge clk);
        data_req = 1'b1;
        repeat (4) @(negedge clk);
        sn = stop_n;
        repeat (4) @(negedge clk);
    endtask

    // Negedges counted from the last data_req rise until running drops.
    task automatic waitIdle(output int n);
        n = 8;
        while (running === 1'b1 && n < 80) begin
            @(negedge clk);
            n++;
        end
    endtask

    logic [15:0] t1_exp [8] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                                16'h0000, 16'h0000, 16'h0000, 16'h0000};

    initial begin
        logic [15:0] word;
        logic        sn;
        int          n;
        int          idx;
        logic        acc;

        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        enable         = 1'b0;
        word_size_in   = 1'b0;
        data_req       = 1'b0;
        up_if.in_valid = 1'b0;
        up_if.in_data  = 16'h0;

        resetDut();
        checkOutput("rst_in_ready", up_if.in_ready, 1'b1);
        checkOutput("rst_data_out", data_out, 16'h0);
        checkOutput("rst_start_n", start_n, 1'b1);
        checkOutput("rst_stop_n", stop_n, 1'b1);
        checkOutput("rst_word_size", word_size, 1'b0);
        checkOutput("rst_running", running, 1'b0);
        checkOutput("rst_underrun", underrun, 1'b0);
`ifdef I2S_STREAM_CTRL_UNDERRUN_CNT_EN
        checkOutput("rst_underrun_cnt", underrun_cnt, 8'd0);
`endif

        $display("[TB] prefill, start and underrun");
        for (int i = 0; i < 4; i++) writeWord(t1_exp[i]);
        enable = 1'b1;
        waitStart();
        checkOutput("t1_running", running, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(1'b0, 16'h0, word, sn);
            checkOutput($sformatf("t1_word%0d", k), word, t1_exp[k-1]);
            checkOutput($sformatf("t1_stop_n%0d", k), sn, 1'b1);
            checkOutput($sformatf("t1_underrun%0d", k), underrun, (k >= 5) ? 1'b1 : 1'b0);
`ifdef I2S_STREAM_CTRL_UNDERRUN_CNT_EN
            checkOutput($sformatf("t1_ucnt%0d", k), underrun_cnt, (k >= 5) ? k - 4 : 0);
`endif
            if (k == 1) checkOutput("t1_start_n_released", start_n, 1'b1);
        end

        $display("[TB] mid-run reset");
        writeWord(16'hDEAD);
        writeWord(16'hBEEF);
        applyStimulus(1'b0, 16'h0, word, sn);
        checkOutput("t6_underrun_word", word, 16'h0000);
        checkOutput("t6_head_loaded", data_out, 16'hBEEF);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_data_out", data_out, 16'h0);
        checkOutput("t6_running", running, 1'b0);
        checkOutput("t6_underrun", underrun, 1'b0);
        checkOutput("t6_start_n", start_n, 1'b1);
        checkOutput("t6_stop_n", stop_n, 1'b1);
        checkOutput("t6_in_ready", up_if.in_ready, 1'b1);
        resetDut();

        $display("[TB] stop on frame boundary, 16-bit slots");
        for (int i = 1; i <= 4; i++) writeWord(16'(16'hA000 + i));
        enable = 1'b1;
        waitStart();
        checkOutput("t3_word_size", word_size, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b1, 16'(16'hA004 + k), word, sn);
            checkOutput($sformatf("t3_word%0d", k), word, 16'(16'hA000 + k));
            checkOutput($sformatf("t3_stop_n%0d", k), sn, (k == 4) ? 1'b0 : 1'b1);
            if (k == 3) enable = 1'b0;
        end
        waitIdle(n);
        checkOutput("t3_idle_delay", n, 21);
        checkOutput("t3_stop_n_idle", stop_n, 1'b1);
        checkOutput("t3_no_underrun", underrun, 1'b0);

        $display("[TB] stop on frame boundary, 32-bit slots");
        resetDut();
        word_size_in = 1'b1;
        for (int i = 1; i <= 4; i++) writeWord(16'(16'hB000 + i));
        enable = 1'b1;
        waitStart();
        checkOutput("t4_word_size", word_size, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(k <= 4, 16'(16'hB004 + k), word, sn);
            checkOutput($sformatf("t4_word%0d", k), word, 16'(16'hB000 + k));
            checkOutput($sformatf("t4_stop_n%0d", k), sn, (k == 8) ? 1'b0 : 1'b1);
            if (k == 5) enable = 1'b0;
        end
        waitIdle(n);
        checkOutput("t4_idle_delay", n, 21);
        checkOutput("t4_running", running, 1'b0);

        $display("[TB] fill to depth");
        resetDut();
        word_size_in   = 1'b0;
        idx            = 0;
        up_if.in_valid = 1'b1;
        up_if.in_data  = 16'hC001;
        for (int i = 0; i < 10; i++) begin
            acc = up_if.in_ready;
            @(negedge clk);
            if (acc) begin
                idx++;
                up_if.in_data = 16'(16'hC001 + idx);
            end
        end
        checkOutput("t5_accepted", idx, 8);
        checkOutput("t5_full_in_ready", up_if.in_ready, 1'b0);
        enable = 1'b1;
        waitStart();
        applyStimulus(1'b0, 16'h0, word, sn);
        checkOutput("t5_word1", word, 16'hC001);
        checkOutput("t5_refilled_in_ready", up_if.in_ready, 1'b0);
        up_if.in_valid = 1'b0;
        for (int k = 2; k <= 10; k++) begin
            applyStimulus(1'b0, 16'h0, word, sn);
            checkOutput($sformatf("t5_word%0d", k), word, (k <= 9) ? 16'(16'hC000 + k) : 16'h0000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
